// File: rtl/dbus_arbiter_pkg.sv
// rtl/dbus_arbiter_pkg.sv - shared constants, response-FSM states and address decode
package dbus_arbiter_pkg;

    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 13;
    localparam int DMEMWORDBITS = 2;
    localparam int MEMIDX_BITS  = DMEMADDRBITS - DMEMWORDBITS;

    localparam logic [DBITS-1:0] ADDRHEX  = 32'hF000_0000;
    localparam logic [DBITS-1:0] ADDRLEDR = 32'hF000_0004;
    localparam logic [DBITS-1:0] ADDRLEDG = 32'hF000_0008;
    localparam logic [DBITS-1:0] ADDRKEY  = 32'hF000_0010;
    localparam logic [DBITS-1:0] ADDRSW   = 32'hF000_0014;

    localparam logic [DBITS-1:0] RD_UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [15:0]      HEX_RESET   = 16'hDEAD;

    typedef enum logic {RIDLE, RPEND} resp_state_t;

    typedef enum logic [2:0] {K_MEM, K_HEX, K_LEDR, K_LEDG, K_KEY, K_SW, K_NONE} addr_kind_t;

    function automatic addr_kind_t decode_addr(input logic [DBITS-1:0] addr);
        if (addr[DBITS-1:DMEMADDRBITS] == '0) begin
            return K_MEM;
        end
        case (addr)
            ADDRHEX:  return K_HEX;
            ADDRLEDR: return K_LEDR;
            ADDRLEDG: return K_LEDG;
            ADDRKEY:  return K_KEY;
            ADDRSW:   return K_SW;
            default:  return K_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// rtl/dbus_arbiter_if.sv - two-requester data bus seen by the arbiter
interface dbus_arbiter_if;
    import dbus_arbiter_pkg::*;

    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [DBITS-1:0] addr0;
    logic [DBITS-1:0] addr1;
    logic [DBITS-1:0] wdata0;
    logic [DBITS-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [DBITS-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a one-bit last-winner pointer
module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last;

    // Under contention the port that did not win last time gets the bus.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b0;
        end else if (req0 && req1) begin
            last <= ~last;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - shared data-bus arbiter with memory window, board I/O and read response stage
module dbus_arbiter
    import dbus_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    dbus_arbiter_if.slave          bus,
    output logic                   mem_we,
    output logic [MEMIDX_BITS-1:0] mem_addr,
    output logic [DBITS-1:0]       mem_wdata,
    input  logic [DBITS-1:0]       mem_rdata,
    input  logic [3:0]             KEY,
    input  logic [9:0]             SW,
    output logic [15:0]            hex_out,
    output logic [9:0]             ledr,
    output logic [7:0]             ledg
);

    logic             gnt0;
    logic             gnt1;
    logic             granted;
    logic             sel_we;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    addr_kind_t       kind;
    logic             rd_go;
    logic             wr_go;

    logic [3:0]       key_s1, key_s;
    logic [9:0]       sw_s1, sw_s;
    logic [DBITS-1:0] io_rd_val;

    resp_state_t      state, state_next;
    logic             port_q;
    logic             mem_q;
    logic [DBITS-1:0] io_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    assign granted   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? bus.we1    : bus.we0;
    assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
    assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    assign kind      = decode_addr(sel_addr);
    assign rd_go     = granted & ~sel_we;
    assign wr_go     = granted & sel_we;

    assign mem_we    = wr_go && (kind == K_MEM);
    assign mem_addr  = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign mem_wdata = sel_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= '0;
            key_s  <= '0;
            sw_s1  <= '0;
            sw_s   <= '0;
        end else begin
            key_s1 <= KEY;
            key_s  <= key_s1;
            sw_s1  <= SW;
            sw_s   <= sw_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out <= HEX_RESET;
            ledr    <= '0;
            ledg    <= '0;
        end else if (wr_go) begin
            case (kind)
                K_HEX:   hex_out <= sel_wdata[15:0];
                K_LEDR:  ledr    <= sel_wdata[9:0];
                K_LEDG:  ledg    <= sel_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Non-memory read data is captured at grant; memory data arrives a cycle later.
    always_comb begin
        io_rd_val = RD_UNMAPPED;
        case (kind)
            K_MEM:   io_rd_val = '0;
            K_HEX:   io_rd_val = {{(DBITS-16){1'b0}}, hex_out};
            K_LEDR:  io_rd_val = {{(DBITS-10){1'b0}}, ledr};
            K_LEDG:  io_rd_val = {{(DBITS-8){1'b0}}, ledg};
            K_KEY:   io_rd_val = {{(DBITS-4){1'b0}}, ~key_s};
            K_SW:    io_rd_val = {{(DBITS-10){1'b0}}, sw_s};
            default: io_rd_val = RD_UNMAPPED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RIDLE;
            port_q <= 1'b0;
            mem_q  <= 1'b0;
            io_q   <= '0;
        end else begin
            state <= state_next;
            if (rd_go) begin
                port_q <= gnt1;
                mem_q  <= (kind == K_MEM);
                io_q   <= io_rd_val;
            end
        end
    end

    always_comb begin
        state_next  = RIDLE;
        bus.rvalid0 = 1'b0;
        bus.rvalid1 = 1'b0;
        bus.rdata   = '0;
        case (state)
            RIDLE: begin
                if (rd_go) state_next = RPEND;
            end
            RPEND: begin
                if (rd_go) state_next = RPEND;
                bus.rvalid0 = ~port_q;
                bus.rvalid1 = port_q;
                bus.rdata   = mem_q ? mem_rdata : io_q;
            end
            default: state_next = RIDLE;
        endcase
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - directed and randomized bench for dbus_arbiter against a behavioural model
module tb_dbus_arbiter;

    localparam logic [31:0] A_HEX  = 32'hF000_0000;
    localparam logic [31:0] A_LEDR = 32'hF000_0004;
    localparam logic [31:0] A_LEDG = 32'hF000_0008;
    localparam logic [31:0] A_KEY  = 32'hF000_0010;
    localparam logic [31:0] A_SW   = 32'hF000_0014;

    logic        clk;
    logic        reset_n;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] hex_out;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    dbus_arbiter_if bus ();

    dbus_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .KEY       (KEY),
        .SW        (SW),
        .hex_out   (hex_out),
        .ledr      (ledr),
        .ledg      (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:2047];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Requester state: a request stays up until the model says it was granted.
    bit          p_req [2];
    bit          p_we  [2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wd  [2];
    bit          rst_mid = 1'b0;

    bit          m_last;
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [31:0] m_mem [0:2047];
    logic [3:0]  key_hist [1:2];
    logic [9:0]  sw_hist  [1:2];
    bit          pend;
    int          pend_port;
    logic [31:0] pend_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        p_req[p]  = 1'b1;
        p_we[p]   = we;
        p_addr[p] = a;
        p_wd[p]   = d;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'h2000) return m_mem[a >> 2];
        if (a == A_HEX)   return {16'h0, m_hex};
        if (a == A_LEDR)  return {22'h0, m_ledr};
        if (a == A_LEDG)  return {24'h0, m_ledg};
        if (a == A_KEY)   return {28'h0, ~key_hist[2]};
        if (a == A_SW)    return {22'h0, sw_hist[2]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_last      = 1'b0;
        m_hex       = 16'hDEAD;
        m_ledr      = '0;
        m_ledg      = '0;
        pend        = 1'b0;
        key_hist[1] = '0;
        key_hist[2] = '0;
        sw_hist[1]  = '0;
        sw_hist[2]  = '0;
    endtask

    // One bus cycle: drive, check mid-cycle against the model, advance the model, cross the edge.
    task automatic cycle();
        int          g;
        logic [31:0] a;
        bit          is_mem;
        bit          next_pend;
        bus.req0   = p_req[0];
        bus.we0    = p_we[0];
        bus.addr0  = p_addr[0];
        bus.wdata0 = p_wd[0];
        bus.req1   = p_req[1];
        bus.we1    = p_we[1];
        bus.addr1  = p_addr[1];
        bus.wdata1 = p_wd[1];
        #3;
        g = -1;
        if (reset_n) begin
            if (p_req[0] && p_req[1]) g = m_last ? 0 : 1;
            else if (p_req[0])        g = 0;
            else if (p_req[1])        g = 1;
        end
        chk("gnt0", {31'h0, bus.gnt0}, {31'h0, g == 0});
        chk("gnt1", {31'h0, bus.gnt1}, {31'h0, g == 1});
        chk("rvalid0", {31'h0, bus.rvalid0}, {31'h0, pend && pend_port == 0});
        chk("rvalid1", {31'h0, bus.rvalid1}, {31'h0, pend && pend_port == 1});
        if (pend) chk("rdata", bus.rdata, pend_data);
        if (!reset_n) chk("rdata_reset", bus.rdata, 32'h0);
        chk("hex_out", {16'h0, hex_out}, {16'h0, m_hex});
        chk("ledr", {22'h0, ledr}, {22'h0, m_ledr});
        chk("ledg", {24'h0, ledg}, {24'h0, m_ledg});
        a      = (g >= 0) ? p_addr[g] : 32'h0;
        is_mem = (g >= 0) && (a < 32'h2000);
        if (g >= 0 && p_we[g]) begin
            chk("mem_we_wr", {31'h0, mem_we}, {31'h0, is_mem});
            if (is_mem) begin
                chk("mem_addr", {21'h0, mem_addr}, a >> 2);
                chk("mem_wdata", mem_wdata, p_wd[g]);
            end
        end else begin
            chk("mem_we_idle", {31'h0, mem_we}, 32'h0);
        end
        if (rst_mid) begin
            reset_n = 1'b0;
            rst_mid = 1'b0;
        end
        if (!reset_n) begin
            model_reset();
            p_req[0] = 1'b0;
            p_req[1] = 1'b0;
        end else begin
            next_pend = 1'b0;
            if (g >= 0) begin
                if (p_we[g]) begin
                    if (is_mem)      m_mem[a >> 2] = p_wd[g];
                    else if (a == A_HEX)  m_hex  = p_wd[g][15:0];
                    else if (a == A_LEDR) m_ledr = p_wd[g][9:0];
                    else if (a == A_LEDG) m_ledg = p_wd[g][7:0];
                end else begin
                    next_pend = 1'b1;
                    pend_port = g;
                    pend_data = model_read(a);
                end
                if (p_req[0] && p_req[1]) m_last = (g == 1);
                p_req[g] = 1'b0;
            end
            pend        = next_pend;
            key_hist[2] = key_hist[1];
            key_hist[1] = KEY;
            sw_hist[2]  = sw_hist[1];
            sw_hist[1]  = SW;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            4:          a = 32'h0000_1FFC;
            5:          a = A_HEX;
            6:          a = A_LEDR;
            7:          a = A_LEDG;
            8:          a = ($urandom_range(0, 1) == 0) ? A_KEY : A_SW;
            default: begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h0000_2000;
                    1:       a = 32'hF000_000C;
                    default: a = 32'h8000_0000;
                endcase
            end
        endcase
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) begin
            tb_mem[i] = 32'h0;
            m_mem[i]  = 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            p_req[p]  = 1'b0;
            p_we[p]   = 1'b0;
            p_addr[p] = 32'h0;
            p_wd[p]   = 32'h0;
        end
        pend_port = 0;
        pend_data = 32'h0;
        KEY       = 4'hF;
        SW        = 10'h0;
        model_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset: requests held during reset must not be granted.
        set_req(0, 1'b0, 32'h100, 32'h0);
        cycle();
        set_req(0, 1'b1, A_HEX, 32'h1234);
        cycle();
        reset_n = 1'b1;
        cycle();

        // Single-port memory write then read.
        set_req(0, 1'b1, 32'h100, 32'h1234_5678);
        cycle();
        set_req(0, 1'b0, 32'h100, 32'h0);
        cycle();
        cycle();
        chk("mem_readback_seen", tb_mem[11'h40], 32'h1234_5678);

        // Contention: both held for four cycles, then drain.
        for (int i = 0; i < 4; i++) begin
            if (!p_req[0]) set_req(0, 1'b0, 32'h100, 32'h0);
            if (!p_req[1]) set_req(1, 1'b0, A_HEX, 32'h0);
            cycle();
        end
        cycle();
        cycle();

        // Board I/O from port 1.
        SW  = 10'h2A5;
        KEY = 4'b0101;
        set_req(1, 1'b1, A_HEX, 32'h0000_BEEF);
        cycle();
        set_req(1, 1'b1, A_LEDR, 32'hFFFF_F3FF);
        cycle();
        set_req(1, 1'b0, A_SW, 32'h0);
        cycle();
        set_req(1, 1'b1, A_LEDG, 32'h0000_01A5);
        cycle();
        set_req(1, 1'b0, A_KEY, 32'h0);
        cycle();
        set_req(1, 1'b0, A_LEDR, 32'h0);
        cycle();
        cycle();
        chk("hex_beef", {16'h0, hex_out}, 32'h0000_BEEF);
        chk("ledr_3ff", {22'h0, ledr}, 32'h0000_03FF);

        // Unmapped read and write, then the window boundary.
        set_req(0, 1'b0, 32'h8000_0000, 32'h0);
        cycle();
        set_req(0, 1'b1, 32'h8000_0000, 32'h5555_5555);
        cycle();
        set_req(1, 1'b0, 32'h0000_2000, 32'h0);
        cycle();
        chk("hex_after_unmapped", {16'h0, hex_out}, 32'h0000_BEEF);

        // Read-after-write across ports at the top of the memory window.
        set_req(0, 1'b1, 32'h0000_1FFC, 32'hCAFE_F00D);
        cycle();
        set_req(1, 1'b0, 32'h0000_1FFC, 32'h0);
        cycle();
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        cycle();
        cycle();

        // Reset lands in the cycle a read is granted.
        set_req(0, 1'b0, 32'h100, 32'h0);
        rst_mid = 1'b1;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        cycle();
        chk("hex_after_midreset", {16'h0, hex_out}, 32'h0000_DEAD);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            KEY = 4'($urandom);
            SW  = 10'($urandom);
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 9) < 7) begin
                    set_req(p, $urandom_range(0, 1) == 1, pick_addr(), $urandom);
                end
            end
            cycle();
        end
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Shares the processor's single data bus between two requesters: port 0 is the CPU load/store path, port 1 is a debug/loader master. It owns the bus-side decode for the data memory window and the memory-mapped I/O registers (HEX, LEDR, LEDG, KEY, SW). It sits between the CPU datapath and the data-memory array plus board I/O. One access is granted per cycle. Reads return a fixed one cycle after grant.

## Interface
- DBITS, 32, data/address width
- DMEMADDRBITS, 13, byte-address bits decoded into the data-memory window
- DMEMWORDBITS, 2, byte-offset bits dropped to form the word index
- ADDRHEX / ADDRLEDR / ADDRLEDG / ADDRKEY / ADDRSW, 32'hF0000000 / F0000004 / F0000008 / F0000010 / F0000014, I/O register addresses
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  access request, held high until granted
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  DBITS each  byte address
- wdata0, wdata1  in  DBITS each  write data
- gnt0, gnt1  out  1 each  one-cycle grant pulse
- rvalid0, rvalid1  out  1 each  read-data-valid pulse
- rdata  out  DBITS  read data, shared, qualified by rvalidN
- mem_we  out  1  data-memory write enable
- mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  word index
- mem_wdata  out  DBITS  memory write data
- mem_rdata  in  DBITS  memory read data, synchronous, 1-cycle latency
- KEY  in  4  raw pushbuttons, active-low
- SW  in  10  raw switches
- hex_out  out  16  HEX display value
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

## Operation
- Arbitration is round-robin with a 1-bit pointer `last`, reset value 0. When only one port requests, that port is granted. When both request, the port not equal to `last` is granted and `last` is updated to the granted port.
- A grant is combinational from the req inputs and the current state: `gntN` is high in the same cycle as the accepted `reqN`. The requester drops or changes `reqN` on the next edge.
- Address decode:
  - Memory window when `addr[DBITS-1:DMEMADDRBITS]` is 0.
  - I/O register on an exact match with one of the five addresses.
  - Otherwise unmapped.
- Granted write:
  - Memory window: `mem_we` = 1 in the grant cycle.
  - ADDRHEX: `hex_out` <= `wdata[15:0]`.
  - ADDRLEDR: `ledr` <= `wdata[9:0]`.
  - ADDRLEDG: `ledg` <= `wdata[7:0]`.
  - Any other address: the write is dropped.
- Granted read: the response stage registers the port, the source and the I/O value. Next cycle, `rvalidN` = 1 and `rdata` is:
  - `mem_rdata` for the memory window
  - `{28'b0, ~key_s}` for KEY
  - `{22'b0, sw_s}` for SW
  - the current register value for HEX/LEDR/LEDG reads
  - 32'hDEADBEEF for unmapped addresses
- `key_s` and `sw_s` are 2-flop synchronizers of KEY and SW.
- Response FSM states:
  - RIDLE: no response pending.
  - RPEND: a read response is driven this cycle.
  - Transitions: RIDLE -> RPEND on a granted read. RPEND -> RPEND on a granted read in the same cycle (back-to-back). RPEND -> RIDLE otherwise.
- Reset (async assert) values:
  - gnt0, gnt1, rvalid0, rvalid1, mem_we = 0
  - rdata = 0
  - hex_out = 16'hDEAD, ledr = 0, ledg = 0
  - `last` = 0, FSM = RIDLE, synchronizers = 0
- Reset asserted mid-operation aborts any pending response: no `rvalid` is issued after reset release.

## Timing
- Grant latency: 0 cycles from `req` when the port wins arbitration. The maximum wait under contention is 1 cycle.
- Read latency: `rvalid` is exactly 1 cycle after `gnt`. Throughput is 1 access per cycle, with back-to-back reads to either port.
- Write effect: the register or memory is updated at the clock edge ending the grant cycle. A read granted in the next cycle sees the new value.
- Simultaneous requests: only one grant per cycle. The losing request is granted in the following cycle if it is still held.
- Read-after-write to the same address in consecutive cycles from different ports returns the written data.
- KEY/SW reads reflect the pin state 2 cycles old, plus 1 cycle of read latency.
- `mem_addr` and `mem_wdata` are don't-care when nothing is granted. They must not toggle `mem_we`.

## Structure
- A shared package holds DBITS, the address constants, the 32'hDEADBEEF sentinel, and the response-FSM state enum (RIDLE, RPEND).
- One sub-module, `rr_arb2`: the 2-way round-robin arbiter with its `last` register. Decode, I/O registers and the response stage stay in `dbus_arbiter`.

## Test plan
- Reset: hold reset_n low, then release. Required: hex_out = DEAD, ledr = 0, ledg = 0, no gnt or rvalid pulses.
- Single-port memory: port 0 writes 32'h12345678 to 0x100, then reads 0x100. Required: gnt0 each cycle, mem_we pulses once, rvalid0 one cycle after the read grant with rdata = 12345678.
- Contention: req0 and req1 both held for 4 cycles. Required: grants alternate 1, 0, 1, 0 (starting from last = 0), and rvalid routes to the correct port.
- I/O: port 1 writes 0xBEEF to ADDRHEX and 0x3FF to ADDRLEDR, then reads ADDRSW with SW = 10'h2A5. Required: hex_out = BEEF, ledr = 3FF, rdata = 0x2A5.
- Unmapped address: read 0x8000_0000. Required: rdata = DEADBEEF. A write to the same address leaves mem_we, hex_out, ledr and ledg unchanged.
- Reset mid-read: assert reset_n low in the cycle a read is granted. Required: no rvalid after release, and all outputs at their reset values.
